// File: rtl/rv32i_pkg.sv
// Shared RV32I load-path definitions: funct3 load encodings, the load FSM state
// type, data-memory geometry and small decode helpers used by the load unit.
package rv32i_pkg;

    localparam int DMEM_ADDR_WIDTH = 8;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        DONE = 2'd3
    } load_state_t;

    function automatic logic is_legal_load(input logic [2:0] funct3);
        return funct3 inside {LB, LH, LW, LBU, LHU};
    endfunction

    // A load needs a second word when its bytes cross the word boundary.
    function automatic logic is_split_load(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            LH, LHU: return offset == 2'd3;
            LW:      return offset != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend_rv32i.sv
// Combinational byte alignment and sign/zero extension of a (possibly two-word)
// load window into the 32-bit writeback value.
module load_extend_rv32i
    import rv32i_pkg::*;
(
    input  logic [63:0] words,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] window;

    assign window = 32'(words >> {offset, 3'b000});

    always_comb begin
        result = '0;
        case (funct3)
            LB:      result = {{24{window[7]}}, window[7:0]};
            LH:      result = {{16{window[15]}}, window[15:0]};
            LW:      result = window;
            LBU:     result = {24'h0, window[7:0]};
            LHU:     result = {16'h0, window[15:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_unit_rv32i.sv
// RV32I load unit: sequences synchronous-read RAM word fetches, stalls the core for
// the read latency and merges two words for misaligned halfword/word loads.
module load_unit_rv32i
    import rv32i_pkg::*;
#(
    parameter int ADDR_WIDTH   = DMEM_ADDR_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cu_load,
    input  logic [2:0]            cu_loadtype,
    input  logic [31:0]           dmem_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  load_fault,
    output logic                  stall
);

    load_state_t           state;
    load_state_t           next_state;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [ADDR_WIDTH-1:0] next_idx;
    logic [1:0]            offset;
    logic [2:0]            ltype;
    logic                  fault;
    logic [1:0]            lat_cnt;
    logic                  cnt_done;
    logic                  split;
    logic                  req_legal;
    logic [31:0]           w0;
    logic [63:0]           ext_words;
    logic [31:0]           ext_data;
    logic                  unused_addr_bits;

    assign next_idx         = word_idx + ADDR_WIDTH'(1);
    assign cnt_done         = (lat_cnt == 2'd1);
    assign split            = is_split_load(ltype, offset);
    assign req_legal        = is_legal_load(cu_loadtype);
    assign unused_addr_bits = ^dmem_addr[31:ADDR_WIDTH+2];

    // An unsplit access never reaches the upper half, so it is only meaningful in RD1.
    assign ext_words = (state == RD1) ? {mem_rdata, w0} : {32'h0, mem_rdata};

    load_extend_rv32i u_extend (
        .words  (ext_words),
        .offset (offset),
        .funct3 (ltype),
        .result (ext_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The second word index goes out in the same cycle the first word lands, so a
    // pipelined RAM returns it exactly one latency later.
    always_comb begin
        next_state = state;
        mem_addr   = word_idx;
        stall      = 1'b0;
        load_valid = 1'b0;
        load_fault = 1'b0;
        case (state)
            IDLE: begin
                mem_addr = dmem_addr[ADDR_WIDTH+1:2];
                stall    = cu_load;
                if (cu_load) begin
                    next_state = req_legal ? RD0 : DONE;
                end
            end
            RD0: begin
                stall = 1'b1;
                if (cnt_done) begin
                    if (split) begin
                        mem_addr   = next_idx;
                        next_state = RD1;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            RD1: begin
                stall    = 1'b1;
                mem_addr = next_idx;
                if (cnt_done) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                load_valid = 1'b1;
                load_fault = fault;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_idx  <= '0;
            offset    <= '0;
            ltype     <= '0;
            fault     <= 1'b0;
            lat_cnt   <= '0;
            w0        <= '0;
            load_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cu_load) begin
                        word_idx <= dmem_addr[ADDR_WIDTH+1:2];
                        offset   <= dmem_addr[1:0];
                        ltype    <= cu_loadtype;
                        lat_cnt  <= 2'(READ_LATENCY);
                        fault    <= !req_legal;
                        if (!req_legal) begin
                            load_data <= '0;
                        end
                    end
                end
                RD0: begin
                    if (cnt_done) begin
                        w0      <= mem_rdata;
                        lat_cnt <= 2'(READ_LATENCY);
                        if (!split) begin
                            load_data <= ext_data;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                RD1: begin
                    if (cnt_done) begin
                        load_data <= ext_data;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit_rv32i.sv
// Self-checking bench for load_unit_rv32i: one instance per read latency (1 and 2),
// each fed by a pipelined RAM model and checked against a byte-level load model.
module tb_load_unit_rv32i;

    logic        clock = 1'b0;
    logic        reset       [2];
    logic        cu_load     [2];
    logic [2:0]  cu_loadtype [2];
    logic [31:0] dmem_addr   [2];
    logic [7:0]  mem_addr    [2];
    logic [31:0] mem_rdata   [2];
    logic [31:0] load_data   [2];
    logic        load_valid  [2];
    logic        load_fault  [2];
    logic        stall       [2];

    logic [31:0] mem [256];
    logic [31:0] ram2_stage;
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // RAM models: unit 0 has one register stage, unit 1 has two
    always @(posedge clock) begin
        mem_rdata[0] <= mem[mem_addr[0]];
        ram2_stage   <= mem[mem_addr[1]];
        mem_rdata[1] <= ram2_stage;
    end

    load_unit_rv32i #(.ADDR_WIDTH(8), .READ_LATENCY(1)) dut_l1 (
        .clock(clock), .reset(reset[0]), .cu_load(cu_load[0]), .cu_loadtype(cu_loadtype[0]),
        .dmem_addr(dmem_addr[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
        .load_data(load_data[0]), .load_valid(load_valid[0]), .load_fault(load_fault[0]),
        .stall(stall[0])
    );

    load_unit_rv32i #(.ADDR_WIDTH(8), .READ_LATENCY(2)) dut_l2 (
        .clock(clock), .reset(reset[1]), .cu_load(cu_load[1]), .cu_loadtype(cu_loadtype[1]),
        .dmem_addr(dmem_addr[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
        .load_data(load_data[1]), .load_valid(load_valid[1]), .load_fault(load_fault[1]),
        .stall(stall[1])
    );

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 2;
    endfunction

    function automatic logic [7:0] byte_at(input int b);
        logic [31:0] w;
        w = mem[(b / 4) % 256];
        return w[8*(b % 4) +: 8];
    endfunction

    function automatic int load_size(input logic [2:0] t);
        case (t)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    // Little-endian byte gather over the 1 KiB space, then extension
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] t);
        int          base;
        int          size;
        logic [31:0] v;
        base = int'(a[9:0]);
        size = load_size(t);
        v    = '0;
        for (int k = 0; k < size; k++) begin
            v = v | (32'(byte_at((base + k) % 1024)) << (8 * k));
        end
        if (t == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
        if (t == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    function automatic int model_latency(input logic [31:0] a, input logic [2:0] t, input int lat);
        int size;
        size = load_size(t);
        if (size == 0) return 1;
        if (int'(a[1:0]) + size > 4) return 2 * lat + 1;
        return lat + 1;
    endfunction

    // Drives one request starting at a negedge in IDLE and records what the unit did.
    task automatic do_load(input int u, input logic [31:0] a, input logic [2:0] t,
                           output int vcyc, output int vabs, output logic [31:0] data,
                           output logic fault, output bit stall_ok,
                           output logic [7:0] addr_c0, output logic [7:0] addr_cl,
                           output logic [7:0] addr_c2l);
        int lat;
        lat      = lat_of(u);
        vcyc     = -1;
        vabs     = -1;
        data     = '0;
        fault    = 1'b0;
        stall_ok = 1'b1;
        addr_c0  = '0;
        addr_cl  = '0;
        addr_c2l = '0;
        cu_load[u]     = 1'b1;
        dmem_addr[u]   = a;
        cu_loadtype[u] = t;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (k == 0)       addr_c0  = mem_addr[u];
            if (k == lat)     addr_cl  = mem_addr[u];
            if (k == 2 * lat) addr_c2l = mem_addr[u];
            if (load_valid[u] === 1'b1) begin
                vcyc  = k;
                vabs  = cyc;
                data  = load_data[u];
                fault = load_fault[u];
                if (stall[u] !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (stall[u] !== 1'b1) stall_ok = 1'b0;
            @(negedge clock);
        end
        @(negedge clock);
        cu_load[u] = 1'b0;
    endtask

    task automatic test_reset(input int u);
        cu_load[u]     = 1'b0;
        cu_loadtype[u] = 3'd2;
        dmem_addr[u]   = 32'h0000_0013;
        reset[u]       = 1'b1;
        #1;
        n_checks++;
        if (load_data[u] !== 32'h0) begin n_fail++; $display("[TB] FAIL u%0d reset load_data: got %h expected 0", u, load_data[u]); end
        n_checks++;
        if (load_valid[u] !== 1'b0) begin n_fail++; $display("[TB] FAIL u%0d reset load_valid: got %b expected 0", u, load_valid[u]); end
        n_checks++;
        if (load_fault[u] !== 1'b0) begin n_fail++; $display("[TB] FAIL u%0d reset load_fault: got %b expected 0", u, load_fault[u]); end
        n_checks++;
        if (stall[u] !== 1'b0) begin n_fail++; $display("[TB] FAIL u%0d reset stall: got %b expected 0", u, stall[u]); end
        n_checks++;
        if (mem_addr[u] !== 8'h04) begin n_fail++; $display("[TB] FAIL u%0d reset mem_addr: got %h expected 04", u, mem_addr[u]); end
        @(negedge clock);
        reset[u] = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_aligned(input int u);
        logic [31:0] ta [5] = '{32'h13, 32'h12, 32'h10, 32'h11, 32'h14};
        logic [2:0]  tt [5] = '{3'd0, 3'd5, 3'd1, 3'd4, 3'd2};
        logic [31:0] te [5] = '{32'hFFFFFF88, 32'h00008899, 32'hFFFFAABB, 32'h000000AA, 32'h11223344};
        int vc, va; logic [31:0] d; logic f; bit sok; logic [7:0] a0, al, a2;
        for (int i = 0; i < 5; i++) begin
            do_load(u, ta[i], tt[i], vc, va, d, f, sok, a0, al, a2);
            n_checks++;
            if (d !== te[i]) begin n_fail++; $display("[TB] FAIL u%0d aligned[%0d] data: got %h expected %h", u, i, d, te[i]); end
            n_checks++;
            if (vc != lat_of(u) + 1) begin n_fail++; $display("[TB] FAIL u%0d aligned[%0d] latency: got %0d expected %0d", u, i, vc, lat_of(u) + 1); end
            n_checks++;
            if (f !== 1'b0) begin n_fail++; $display("[TB] FAIL u%0d aligned[%0d] fault: got %b expected 0", u, i, f); end
            n_checks++;
            if (sok !== 1'b1) begin n_fail++; $display("[TB] FAIL u%0d aligned[%0d] stall window: got %b expected 1", u, i, sok); end
            n_checks++;
            if (a0 !== ta[i][9:2]) begin n_fail++; $display("[TB] FAIL u%0d aligned[%0d] mem_addr: got %h expected %h", u, i, a0, ta[i][9:2]); end
        end
    endtask

    task automatic test_split(input int u);
        logic [31:0] ta [3] = '{32'h13, 32'h13, 32'h3FE};
        logic [2:0]  tt [3] = '{3'd2, 3'd1, 3'd2};
        logic [31:0] te [3] = '{32'h22334488, 32'h00004488, 32'hFFEEDEAD};
        logic [7:0]  t0 [3] = '{8'h04, 8'h04, 8'hFF};
        logic [7:0]  t1 [3] = '{8'h05, 8'h05, 8'h00};
        int vc, va; logic [31:0] d; logic f; bit sok; logic [7:0] a0, al, a2;
        for (int i = 0; i < 3; i++) begin
            do_load(u, ta[i], tt[i], vc, va, d, f, sok, a0, al, a2);
            n_checks++;
            if (d !== te[i]) begin n_fail++; $display("[TB] FAIL u%0d split[%0d] data: got %h expected %h", u, i, d, te[i]); end
            n_checks++;
            if (vc != 2 * lat_of(u) + 1) begin n_fail++; $display("[TB] FAIL u%0d split[%0d] latency: got %0d expected %0d", u, i, vc, 2 * lat_of(u) + 1); end
            n_checks++;
            if (sok !== 1'b1) begin n_fail++; $display("[TB] FAIL u%0d split[%0d] stall window: got %b expected 1", u, i, sok); end
            n_checks++;
            if (a0 !== t0[i]) begin n_fail++; $display("[TB] FAIL u%0d split[%0d] first mem_addr: got %h expected %h", u, i, a0, t0[i]); end
            n_checks++;
            if (al !== t1[i] || a2 !== t1[i]) begin n_fail++; $display("[TB] FAIL u%0d split[%0d] second mem_addr: got %h/%h expected %h", u, i, al, a2, t1[i]); end
        end
    endtask

    task automatic test_illegal(input int u);
        logic [2:0] tt [3] = '{3'd3, 3'd6, 3'd7};
        int vc, va; logic [31:0] d; logic f; bit sok; logic [7:0] a0, al, a2;
        for (int i = 0; i < 3; i++) begin
            do_load(u, 32'h14, 3'd2, vc, va, d, f, sok, a0, al, a2);
            do_load(u, 32'h10, tt[i], vc, va, d, f, sok, a0, al, a2);
            n_checks++;
            if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL u%0d illegal[%0d] data: got %h expected 0", u, i, d); end
            n_checks++;
            if (vc != 1) begin n_fail++; $display("[TB] FAIL u%0d illegal[%0d] latency: got %0d expected 1", u, i, vc); end
            n_checks++;
            if (f !== 1'b1) begin n_fail++; $display("[TB] FAIL u%0d illegal[%0d] fault: got %b expected 1", u, i, f); end
            n_checks++;
            if (sok !== 1'b1) begin n_fail++; $display("[TB] FAIL u%0d illegal[%0d] stall window: got %b expected 1", u, i, sok); end
        end
    endtask

    task automatic test_hold(input int u);
        int vc, va; logic [31:0] d; logic f; bit sok; logic [7:0] a0, al, a2;
        logic [31:0] ra;
        do_load(u, 32'h11, 3'd4, vc, va, d, f, sok, a0, al, a2);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            dmem_addr[u] = ra;
            #1;
            n_checks++;
            if (load_data[u] !== 32'h000000AA) begin n_fail++; $display("[TB] FAIL u%0d hold[%0d] load_data: got %h expected 000000aa", u, i, load_data[u]); end
            n_checks++;
            if (load_valid[u] !== 1'b0 || stall[u] !== 1'b0) begin n_fail++; $display("[TB] FAIL u%0d hold[%0d] valid/stall: got %b/%b expected 0/0", u, i, load_valid[u], stall[u]); end
            n_checks++;
            if (mem_addr[u] !== ra[9:2]) begin n_fail++; $display("[TB] FAIL u%0d hold[%0d] mem_addr: got %h expected %h", u, i, mem_addr[u], ra[9:2]); end
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back(input int u);
        logic [31:0] ta [3] = '{32'h14, 32'h13, 32'h12};
        logic [2:0]  tt [3] = '{3'd2, 3'd0, 3'd5};
        logic [31:0] te [3] = '{32'h11223344, 32'hFFFFFF88, 32'h00008899};
        int vc, va, prev; logic [31:0] d; logic f; bit sok; logic [7:0] a0, al, a2;
        prev = -1;
        for (int i = 0; i < 3; i++) begin
            do_load(u, ta[i], tt[i], vc, va, d, f, sok, a0, al, a2);
            n_checks++;
            if (d !== te[i]) begin n_fail++; $display("[TB] FAIL u%0d b2b[%0d] data: got %h expected %h", u, i, d, te[i]); end
            if (i > 0) begin
                n_checks++;
                if (va - prev != lat_of(u) + 2) begin n_fail++; $display("[TB] FAIL u%0d b2b[%0d] spacing: got %0d expected %0d", u, i, va - prev, lat_of(u) + 2); end
            end
            prev = va;
        end
    endtask

    task automatic test_reset_mid(input int u);
        int vc, va; logic [31:0] d; logic f; bit sok; logic [7:0] a0, al, a2;
        bit saw_valid, saw_stall;
        int lat;
        lat = lat_of(u);
        cu_load[u]     = 1'b1;
        dmem_addr[u]   = 32'h13;
        cu_loadtype[u] = 3'd2;
        repeat (lat + 1) @(negedge clock);
        #1;
        n_checks++;
        if (stall[u] !== 1'b1) begin n_fail++; $display("[TB] FAIL u%0d midreset pre stall: got %b expected 1", u, stall[u]); end
        #1;
        reset[u]   = 1'b1;
        cu_load[u] = 1'b0;
        #1;
        n_checks++;
        if (load_data[u] !== 32'h0 || load_valid[u] !== 1'b0 || load_fault[u] !== 1'b0 || stall[u] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL u%0d midreset outputs: got data %h valid %b fault %b stall %b expected all 0", u, load_data[u], load_valid[u], load_fault[u], stall[u]);
        end
        @(negedge clock);
        reset[u]  = 1'b0;
        saw_valid = 1'b0;
        saw_stall = 1'b0;
        for (int k = 0; k < 2 * lat + 3; k++) begin
            #1;
            if (load_valid[u] !== 1'b0) saw_valid = 1'b1;
            if (stall[u] !== 1'b0) saw_stall = 1'b1;
            @(negedge clock);
        end
        n_checks++;
        if (saw_valid || saw_stall) begin n_fail++; $display("[TB] FAIL u%0d midreset discard: got valid %b stall %b expected 0/0", u, saw_valid, saw_stall); end
        do_load(u, 32'h14, 3'd2, vc, va, d, f, sok, a0, al, a2);
        n_checks++;
        if (d !== 32'h11223344) begin n_fail++; $display("[TB] FAIL u%0d midreset follow data: got %h expected 11223344", u, d); end
        n_checks++;
        if (vc != lat + 1) begin n_fail++; $display("[TB] FAIL u%0d midreset follow latency: got %0d expected %0d", u, vc, lat + 1); end
    endtask

    task automatic test_random(input int u);
        logic [2:0] legal [5]   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0] illegal [3] = '{3'd3, 3'd6, 3'd7};
        int vc, va, el; logic [31:0] d, a, ed; logic [2:0] t; logic f; bit sok; logic [7:0] a0, al, a2;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 9) < 2) t = illegal[$urandom_range(0, 2)];
            else                          t = legal[$urandom_range(0, 4)];
            ed = model_load(a, t);
            el = model_latency(a, t, lat_of(u));
            do_load(u, a, t, vc, va, d, f, sok, a0, al, a2);
            n_checks++;
            if (d !== ed) begin n_fail++; $display("[TB] FAIL u%0d rand[%0d] data a=%h t=%0d: got %h expected %h", u, i, a, t, d, ed); end
            n_checks++;
            if (vc != el) begin n_fail++; $display("[TB] FAIL u%0d rand[%0d] latency a=%h t=%0d: got %0d expected %0d", u, i, a, t, vc, el); end
            n_checks++;
            if (f !== (load_size(t) == 0)) begin n_fail++; $display("[TB] FAIL u%0d rand[%0d] fault t=%0d: got %b expected %b", u, i, t, f, load_size(t) == 0); end
            n_checks++;
            if (a0 !== a[9:2] || sok !== 1'b1) begin n_fail++; $display("[TB] FAIL u%0d rand[%0d] addr/stall: got %h/%b expected %h/1", u, i, a0, sok, a[9:2]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[4]   = 32'h8899AABB;
        mem[5]   = 32'h11223344;
        mem[255] = 32'hDEADBEEF;
        mem[0]   = 32'h00C0FFEE;
        for (int u = 0; u < 2; u++) begin
            reset[u]       = 1'b1;
            cu_load[u]     = 1'b0;
            cu_loadtype[u] = 3'd0;
            dmem_addr[u]   = 32'h0;
        end
        @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            $display("[TB] unit %0d, read latency %0d", u, lat_of(u));
            test_reset(u);
            test_aligned(u);
            test_split(u);
            test_illegal(u);
            test_hold(u);
            test_back_to_back(u);
            test_reset_mid(u);
            test_random(u);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
